// File: rtl/trap_pkg.sv
// Shared types and helpers for the trapezoidal shaper: FSM encoding,
// pipeline latency and the output clamp.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_CHECK,
        ST_FILL,
        ST_RUN,
        ST_CFG_ERR
    } state_t;

    localparam int PIPE_LAT = 5;

    // Clamp v into the signed range of a w-bit word (w <= 64).
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        else if (v < lo) return lo;
        else return v;
    endfunction

endpackage

// File: rtl/trap_filter_mc_if.sv
// Sample stream in and shaped stream out; no backpressure on either side.
interface trap_filter_mc_if #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int OUT_WIDTH        = 32
);
    logic signed [AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
    logic                               s_axis_tvalid;
    logic signed [OUT_WIDTH-1:0]        m_axis_tdata;
    logic                               m_axis_tvalid;

    modport master (
        output s_axis_tdata, s_axis_tvalid,
        input  m_axis_tdata, m_axis_tvalid
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid,
        output m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/trap_delay_line.sv
// Circular delay line of depth 2**DEPTH_BITS-1 with read-first registered output;
// advances only when en is high, so the delay is counted in samples, not clocks.
module trap_delay_line #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 14
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DEPTH_BITS-1:0] delay,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data
);
    localparam int DEPTH = 2**DEPTH_BITS - 1;
    localparam logic [DEPTH_BITS-1:0] DEPTH_V = DEPTH_BITS'(DEPTH);
    localparam logic [DEPTH_BITS-1:0] LAST    = DEPTH_BITS'(DEPTH - 1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;

    // delay == DEPTH reads the slot about to be overwritten (read-first)
    assign rd_ptr = (wr_ptr >= delay) ? wr_ptr - delay : wr_ptr + (DEPTH_V - delay);

    always_ff @(posedge clk) begin
        if (en) begin
            rd_data     <= mem[rd_ptr];
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + DEPTH_BITS'(1);
        end
    end
endmodule

// File: rtl/trap_filter_mc.sv
// Jordanov-Knoll trapezoidal shaper with config check, delay-line fill,
// saturated output and sticky overflow.
//   state      | meaning
//   CHECK      | latch K/L/M and validate, one cycle
//   FILL       | prime both delay lines with K+L samples, no output
//   RUN        | full pipeline active
//   CFG_ERR    | illegal config, idle until restart/areset
module trap_filter_mc
    import trap_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int DELAY_WIDTH      = 14,
    parameter int MULT_WIDTH       = 16,
    parameter int FRAC_BITS        = 0,
    parameter int ACC_WIDTH        = 48,
    parameter int OUT_WIDTH        = 32
) (
    input  logic                          clk,
    input  logic                          areset,
    trap_filter_mc_if.slave               axis,
    input  logic [DELAY_WIDTH-1:0]        k_delay,
    input  logic [DELAY_WIDTH-1:0]        l_delay,
    input  logic signed [MULT_WIDTH-1:0]  mult_factor,
    input  logic                          restart,
    output logic                          cfg_err,
    output logic                          ovf,
    output logic                          running
);
    localparam int TW = AXIS_TDATA_WIDTH;
    localparam int FW = DELAY_WIDTH + 1;
    localparam int PW = TW + 2 + MULT_WIDTH;

    state_t                       state, state_nx;
    logic [DELAY_WIDTH-1:0]       k_lat, l_lat;
    logic signed [MULT_WIDTH-1:0] m_lat;
    logic [FW-1:0]                fill_cnt, fill_last;
    logic                         clr, accept, adv;
    logic [PIPE_LAT:0]            live;
    logic signed [TW-1:0]         x_q, xk;
    logic signed [TW:0]           a_comb, a, al;
    logic signed [TW+1:0]         d;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  p, r, s, s_nx;

    assign clr       = areset | restart;
    assign accept    = axis.s_axis_tvalid && (state == ST_FILL || state == ST_RUN);
    assign fill_last = {1'b0, k_lat} + {1'b0, l_lat} - FW'(1);
    assign a_comb    = {x_q[TW-1], x_q} - {xk[TW-1], xk};
    assign s_nx      = s + r;

    always_ff @(posedge clk) begin
        if (areset) state <= ST_CHECK;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_CHECK:   state_nx = (k_delay != '0 && k_delay <= l_delay) ? ST_FILL : ST_CFG_ERR;
            ST_FILL:    if (accept && fill_cnt == fill_last) state_nx = ST_RUN;
            ST_RUN:     state_nx = ST_RUN;
            ST_CFG_ERR: state_nx = ST_CFG_ERR;
            default:    state_nx = ST_CHECK;
        endcase
        if (restart) state_nx = ST_CHECK;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            k_lat    <= '0;
            l_lat    <= '0;
            m_lat    <= '0;
            fill_cnt <= '0;
        end else begin
            if (state == ST_CHECK) begin
                k_lat <= k_delay;
                l_lat <= l_delay;
                m_lat <= mult_factor;
            end
            if (state == ST_FILL && accept) fill_cnt <= fill_cnt + FW'(1);
        end
    end

    // Fill samples advance the delay lines; only RUN samples reach the accumulators.
    always_ff @(posedge clk) begin
        if (clr) begin
            adv  <= 1'b0;
            live <= '0;
            x_q  <= '0;
            a    <= '0;
            d    <= '0;
            p    <= '0;
            prod <= '0;
            r    <= '0;
            s    <= '0;
            ovf  <= 1'b0;
        end else begin
            adv  <= accept;
            live <= {live[PIPE_LAT-1:0], accept && state == ST_RUN};
            if (accept) x_q <= axis.s_axis_tdata;
            if (adv) a <= a_comb;
            if (live[1]) d <= {a[TW], a} - {al[TW], al};
            if (live[2]) begin
                p    <= p + ACC_WIDTH'(d);
                prod <= PW'(d) * PW'(m_lat);
            end
            if (live[3]) r <= p + ACC_WIDTH'(prod >>> FRAC_BITS);
            if (live[4]) begin
                s <= s_nx;
                if (saturate(64'(s_nx), OUT_WIDTH) != 64'(s_nx)) ovf <= 1'b1;
            end
        end
    end

    trap_delay_line #(.WIDTH(TW), .DEPTH_BITS(DELAY_WIDTH)) u_line_x (
        .clk     (clk),
        .en      (accept),
        .delay   (k_lat),
        .wr_data (axis.s_axis_tdata),
        .rd_data (xk)
    );

    trap_delay_line #(.WIDTH(TW + 1), .DEPTH_BITS(DELAY_WIDTH)) u_line_a (
        .clk     (clk),
        .en      (adv),
        .delay   (l_lat),
        .wr_data (a_comb),
        .rd_data (al)
    );

    assign axis.m_axis_tdata  = OUT_WIDTH'(saturate(64'(s), OUT_WIDTH));
    assign axis.m_axis_tvalid = live[PIPE_LAT];
    assign running            = (state == ST_RUN);
    assign cfg_err            = (state == ST_CFG_ERR);
endmodule

// File: tb/tb_trap_filter_mc.sv
// Scoreboard bench for trap_filter_mc: a sample-history reference model predicts
// each shaped output and its arrival cycle; a negedge monitor pops and compares.
module tb_trap_filter_mc;
    import trap_pkg::*;

    localparam int TW = 16, DW = 10, MW = 16, FB = 2, AW = 48, OW = 16;
    localparam int MS_CHECK = 0, MS_FILL = 1, MS_RUN = 2, MS_ERR = 3;

    logic                 clk = 1'b0;
    logic                 areset, restart;
    logic [DW-1:0]        k_delay, l_delay;
    logic signed [MW-1:0] mult_factor;
    logic                 cfg_err, ovf, running;

    trap_filter_mc_if #(.AXIS_TDATA_WIDTH(TW), .OUT_WIDTH(OW)) axis ();

    trap_filter_mc #(
        .AXIS_TDATA_WIDTH(TW), .DELAY_WIDTH(DW), .MULT_WIDTH(MW),
        .FRAC_BITS(FB), .ACC_WIDTH(AW), .OUT_WIDTH(OW)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .axis        (axis),
        .k_delay     (k_delay),
        .l_delay     (l_delay),
        .mult_factor (mult_factor),
        .restart     (restart),
        .cfg_err     (cfg_err),
        .ovf         (ovf),
        .running     (running)
    );

    always #5 clk = ~clk;

    typedef struct { longint val; bit ovf; int cyc; } exp_t;
    exp_t   sb[$];
    exp_t   mon_it;
    int     hist[$];
    int     checks = 0, errors = 0, ncyc = 0;
    int     m_st = MS_CHECK, kl = 0, ll = 0, ml = 0;
    longint p_m = 0, s_m = 0;
    bit     ovf_m = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, ncyc);
        end
    endtask

    // Reference: d(n) = x(n) - x(n-K) - x(n-L) + x(n-K-L), then the two accumulators.
    task automatic model_step(input bit rst, input bit rs, input bit v, input int x);
        longint d, r, e;
        int n;
        if (rst || rs) begin
            m_st = MS_CHECK; hist.delete(); p_m = 0; s_m = 0; ovf_m = 0; sb.delete();
        end else begin
            case (m_st)
                MS_CHECK: begin
                    kl = int'(k_delay); ll = int'(l_delay); ml = int'(mult_factor);
                    m_st = (kl >= 1 && kl <= ll) ? MS_FILL : MS_ERR;
                end
                MS_FILL: if (v) begin
                    hist.push_back(x);
                    if (hist.size() == kl + ll) m_st = MS_RUN;
                end
                MS_RUN: if (v) begin
                    hist.push_back(x);
                    n = hist.size() - 1;
                    d = longint'(hist[n]) - hist[n-kl] - hist[n-ll] + hist[n-kl-ll];
                    p_m = p_m + d;
                    r = p_m + ((d * ml) >>> FB);
                    s_m = s_m + r;
                    s_m = (s_m <<< (64 - AW)) >>> (64 - AW);
                    if (s_m > 32767) e = 32767;
                    else if (s_m < -32768) e = -32768;
                    else e = s_m;
                    if (e != s_m) ovf_m = 1;
                    sb.push_back('{e, ovf_m, ncyc + PIPE_LAT});
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit rst, input bit rs, input bit v, input int x);
        areset = rst;
        restart = rs;
        axis.s_axis_tvalid = v;
        axis.s_axis_tdata = TW'(x);
        @(posedge clk);
        model_step(rst, rs, v, x);
        #1;
    endtask

    function automatic int rnd_x(input int amp);
        return int'($urandom_range(2 * amp)) - amp;
    endfunction

    always @(negedge clk) begin
        if (axis.m_axis_tvalid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got tvalid=1 data %0d at cycle %0d, expected none",
                         $signed(axis.m_axis_tdata), ncyc);
            end else begin
                mon_it = sb.pop_front();
                check("beat_data", longint'($signed(axis.m_axis_tdata)), mon_it.val);
                check("beat_cycle", ncyc, mon_it.cyc);
                check("beat_ovf", ovf, mon_it.ovf);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= ncyc) begin
            mon_it = sb.pop_front();
            checks++; errors++;
            $display("FAIL missing_beat: got tvalid=0 at cycle %0d, expected data %0d", ncyc, mon_it.val);
        end
        check("running", running, m_st == MS_RUN);
        check("cfg_err", cfg_err, m_st == MS_ERR);
        ncyc++;
    end

    initial begin
        int kk, lk;
        areset = 1; restart = 0;
        axis.s_axis_tvalid = 0; axis.s_axis_tdata = '0;
        k_delay = 4; l_delay = 8; mult_factor = 0;

        repeat (3) cyc(1, 0, 0, 0);
        check("rst_tvalid", axis.m_axis_tvalid, 0);
        check("rst_tdata", axis.m_axis_tdata, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_ovf", ovf, 0);
        check("rst_running", running, 0);

        // step 0 -> 100, K=4 L=8 M=0
        cyc(0, 0, 0, 0);
        repeat (12) cyc(0, 0, 1, 0);
        check("run_after_fill", running, 1);
        repeat (20) cyc(0, 0, 1, 100);
        repeat (8) cyc(0, 0, 0, 0);

        // same step with tvalid toggling
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 24; i++) cyc(0, 0, (i % 2) == 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0, (i % 2) == 0, 100);
        repeat (8) cyc(0, 0, 0, 0);

        // illegal configs
        k_delay = 0; l_delay = 8;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("k0_cfg_err", cfg_err, 1);
        k_delay = 2; l_delay = 3;
        repeat (10) cyc(0, 0, 1, rnd_x(500));
        check("err_ignores_cfg", cfg_err, 1);
        k_delay = 9; l_delay = 8;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("k_gt_l_cfg_err", cfg_err, 1);
        repeat (10) cyc(0, 0, 1, rnd_x(500));
        k_delay = 2; l_delay = 3;
        cyc(0, 1, 0, 0);
        check("restart_clears_err", cfg_err, 0);
        cyc(0, 0, 0, 0);
        repeat (4) cyc(0, 0, 1, rnd_x(500));
        check("not_running_4", running, 0);
        cyc(0, 0, 1, rnd_x(500));
        check("running_5", running, 1);
        repeat (20) cyc(0, 0, 1, rnd_x(500));

        // saturation with K=L=1000
        k_delay = 1000; l_delay = 1000; mult_factor = 0;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (2000) cyc(0, 0, 1, 0);
        repeat (30) cyc(0, 0, 1, 32767);
        repeat (8) cyc(0, 0, 0, 0);
        check("ovf_sticky", ovf, 1);
        check("clamp_hi", axis.m_axis_tdata, 32767);
        cyc(0, 1, 0, 0);
        check("ovf_cleared", ovf, 0);

        // maximum delays K=L=depth
        k_delay = 1023; l_delay = 1023; mult_factor = MW'(int'($urandom_range(80)) - 20);
        cyc(0, 0, 0, 0);
        repeat (2046) cyc(0, 0, 1, rnd_x(200));
        repeat (40) cyc(0, 0, 1, rnd_x(200));

        // constant baseline from reset
        k_delay = 5; l_delay = 9; mult_factor = MW'(int'($urandom_range(80)) - 20);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 60; i++) cyc(0, 0, $urandom_range(3) != 0, -500);
        repeat (8) cyc(0, 0, 0, 0);
        check("baseline_zero", axis.m_axis_tdata, 0);
        check("baseline_no_ovf", ovf, 0);

        // randomized blocks, ended by mid-RUN restart or areset
        for (int blk = 0; blk < 4; blk++) begin
            kk = int'($urandom_range(12, 1));
            lk = int'($urandom_range(20, kk));
            k_delay = DW'(kk); l_delay = DW'(lk);
            mult_factor = MW'(int'($urandom_range(80)) - 20);
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
            for (int i = 0; i < 350; i++) begin
                if (i == 100) begin
                    k_delay = DW'($urandom_range(30));
                    l_delay = DW'($urandom_range(30));
                end
                cyc(0, 0, $urandom_range(3) != 0, rnd_x(200));
            end
            check("blk_running", running, 1);
            cyc((blk % 2) == 1, (blk % 2) == 0, 1, rnd_x(200));
            check("abort_tvalid", axis.m_axis_tvalid, 0);
            check("abort_tdata", axis.m_axis_tdata, 0);
            check("abort_running", running, 0);
            check("abort_ovf", ovf, 0);
        end

        repeat (10) cyc(0, 0, 0, 0);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
